checkpoint_monitor: RTL and testbench
=====================================

# checkpoint_monitor

Synthesizable checkpoint sequencer and profiler for the firmware checkbit bus (`mprj_io[31:16]`). Firmware writes `{MARK_HI, test_idx, phase}` markers at the start and end of each workload (FIR, matmul, qsort). This block:
- checks that markers arrive in the expected order over `NUM_RUNS` reruns;
- measures the clock count of every test;
- flags ordering errors and an overall watchdog timeout.

It sits beside the user project as an on-chip replacement for the bench-only marker waits, and drives LA/status outputs.

## Interface
Parameters:
- `CHK_W`, 16: checkbit bus width. Must be at least 16.
- `MARK_HI`, 8'hAB: required value of `checkbits[15:8]` for a word to count as a marker.
- `NUM_TESTS`, 3: tests per run, range 1..16. Test index is `checkbits[7:4]`.
- `NUM_RUNS`, 3: number of full reruns expected, range 1..16.
- `CNT_W`, 32: width of the cycle counter.
- `TIMEOUT`, 150000: watchdog limit in clocks.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `checkbits_i` in `CHK_W`: checkbit bus, asynchronous to the clock.
- `start_pulse_o` out 1: one-cycle pulse when the expected start marker is accepted.
- `end_pulse_o` out 1: one-cycle pulse when the expected end marker is accepted.
- `test_idx_o` out 4: index of the current or last test.
- `run_idx_o` out 4: index of the current run.
- `cycles_o` out `CNT_W`: duration of the last completed test, in clocks.
- `cycles_valid_o` out 1: one-cycle pulse, coincident with `end_pulse_o`.
- `done_o` out 1: high once all runs complete. Sticky.
- `error_o` out 1: high once an error occurs. Sticky.
- `err_code_o` out 2: 0 = none, 1 = out-of-order marker, 2 = timeout, 3 = counter saturated.

## Operation
Input qualification:
- Two registers sample the bus: `s1 <= checkbits_i`, `s2 <= s1`.
- A word is accepted when `s1 == s2` and `s2 != last`. `last` is the previously accepted word; it resets to 0.
- Accepting a word updates `last`. This guarantees exactly one event per firmware write, even though firmware holds the value.
- Accepted words with `[15:8] != MARK_HI` are ignored.

Expected marker is `{MARK_HI, t, 4'h0}` for start and `{MARK_HI, t, 4'h1}` for end, where t is the expected test index.

FSM states:
- IDLE: waits for the start marker of test t.
  - On acceptance: pulse `start_pulse_o`, clear the cycle counter, go to RUN.
- RUN: the counter increments every clock and saturates at all-ones.
  - On the end marker for t: latch the counter into `cycles_o` and pulse `end_pulse_o` and `cycles_valid_o`.
  - Then advance t. At t = `NUM_TESTS`-1, wrap t to 0 and increment the run index.
  - After the last test of the last run, go to DONE. Otherwise go to IDLE.
- DONE: `done_o` = 1. All further markers are ignored.
- ERR: `error_o` = 1 and `err_code_o` is frozen. The state is left only by reset.

Errors:
- Any MARK_HI marker other than the one currently expected gives code 1. This covers a wrong test index, an end in IDLE, or a start in RUN.
- Counter saturation in RUN gives code 3. The test still completes: the saturated value is latched, and the error is raised on the end marker.
- Watchdog expiry gives code 2 (see Configuration).

Priority in a single cycle, highest first: timeout, then out-of-order, then saturation. The lower-priority event is discarded.

## Timing
- Reset values: all outputs are 0, `s1`/`s2`/`last` are 0, the FSM is in IDLE, t = 0, run = 0.
- Latency: a marker that is stable at the input from edge k is accepted at edge k+3. The pulse is high during the cycle following that edge.
- `cycles_o` equals the start-to-end acceptance distance in clocks, so the pipeline delay cancels.
- A marker held for fewer than 2 clocks may be missed. Firmware holds each marker for at least 4 clocks.
- The same word written twice in succession counts as one event.
- If `NUM_RUNS` = 1 and `NUM_TESTS` = 1, DONE follows the first end.
- Reset asserted mid-RUN aborts immediately and asynchronously; all state returns to reset values.

## Configuration
`CHKMON_TIMEOUT_EN`:
- Defined: a watchdog counter counts from reset release until DONE or ERR. Reaching `TIMEOUT` moves the FSM to ERR with code 2.
- Undefined: no watchdog logic is built, and code 2 never occurs.

## Test plan
- Nominal sequence, run for 3 runs:
  - Stimulus: AB00, then AB01 500 clocks later, AB10, AB11 (1200 later), AB20, AB21 (800 later), each marker held for 10 clocks.
  - Required response: `cycles_o` = 500/1200/800 on each `cycles_valid_o`, `run_idx_o` steps 0→1→2, then `done_o` = 1.
- Ordering error: AB10 arrives while IDLE expects test 0 → `error_o` = 1, `err_code_o` = 1, and later markers produce no pulses.
- Glitch and duplicates:
  - A 1-clock glitch to AB00 gives no pulse.
  - AB00 held for 50 clocks gives exactly one `start_pulse_o`.
  - A non-marker word such as 0x1234 between markers is ignored.
- Timeout: with the macro defined and `TIMEOUT` = 2000, no markers → `err_code_o` = 2 at clock 2000 after reset. Without the macro, `error_o` stays 0.
- Saturation: with `CNT_W` = 8, a start/end gap of 300 clocks gives `cycles_o` = 255 and `err_code_o` = 3.
- Reset mid-test: reset pulsed during RUN of test 1 → all outputs return to 0, and the FSM again expects AB00.

Source files
------------

// File: rtl/checkpoint_monitor.sv
// Checkpoint sequencer/profiler for the firmware checkbit bus: orders markers, times tests, flags errors.
// Optional watchdog built only when CHKMON_TIMEOUT_EN is defined.
module checkpoint_monitor #(
  parameter int         CHK_W     = 16,
  parameter logic [7:0] MARK_HI   = 8'hAB,
  parameter int         NUM_TESTS = 3,
  parameter int         NUM_RUNS  = 3,
  parameter int         CNT_W     = 32,
  parameter int         TIMEOUT   = 150000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [CHK_W-1:0] checkbits_i,
  output logic             start_pulse_o,
  output logic             end_pulse_o,
  output logic [3:0]       test_idx_o,
  output logic [3:0]       run_idx_o,
  output logic [CNT_W-1:0] cycles_o,
  output logic             cycles_valid_o,
  output logic             done_o,
  output logic             error_o,
  output logic [1:0]       err_code_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam logic [3:0]       LAST_T  = 4'(NUM_TESTS - 1);
  localparam logic [3:0]       LAST_R  = 4'(NUM_RUNS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CHK_W-1:0] s1, s2, last;
  logic [3:0]       t, run;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat_flag;
  logic             acc, is_mark, hit_start, hit_end, ooo, start_ok, end_ok;
  logic             sat_now, final_test, active, wd_hit;

  // One event per firmware write: word must be stable two samples and differ from the last event
  assign acc       = (s1 == s2) && (s2 != last);
  assign is_mark   = acc && (s2[15:8] == MARK_HI);
  assign hit_start = is_mark && (s2[15:0] == {MARK_HI, t, 4'h0});
  assign hit_end   = is_mark && (s2[15:0] == {MARK_HI, t, 4'h1});
  assign active    = (state == IDLE) || (state == RUN);

  assign ooo      = is_mark && (((state == IDLE) && !hit_start) || ((state == RUN) && !hit_end));
  assign start_ok = (state == IDLE) && hit_start && !wd_hit;
  assign end_ok   = (state == RUN) && hit_end && !wd_hit;

  assign cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign sat_now    = sat_flag || (cnt == CNT_MAX);
  assign final_test = (t == LAST_T) && (run == LAST_R);

`ifdef CHKMON_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)    wd <= '0;
    else if (active) wd <= wd + 1'b1;
  end

  assign wd_hit = active && (wd == WD_W'(TIMEOUT - 1));
`else
  // TIMEOUT has no effect without the watchdog
  assign wd_hit = 1'b0 & (TIMEOUT == 0);
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wd_hit || ooo) state_nxt = ERR;
        else if (start_ok) state_nxt = RUN;
      end
      RUN: begin
        if (wd_hit || ooo) state_nxt = ERR;
        else if (end_ok)   state_nxt = sat_now ? ERR : (final_test ? DONE : IDLE);
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = ERR;
    endcase
  end

  always_comb begin
    done_o  = (state == DONE);
    error_o = (state == ERR);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      s1             <= '0;
      s2             <= '0;
      last           <= '0;
      t              <= '0;
      run            <= '0;
      cnt            <= '0;
      sat_flag       <= 1'b0;
      cycles_o       <= '0;
      start_pulse_o  <= 1'b0;
      end_pulse_o    <= 1'b0;
      cycles_valid_o <= 1'b0;
      err_code_o     <= 2'd0;
    end else begin
      s1             <= checkbits_i;
      s2             <= s1;
      start_pulse_o  <= start_ok;
      end_pulse_o    <= end_ok;
      cycles_valid_o <= end_ok;
      if (acc) last <= s2;
      if (start_ok) begin
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else if (state == RUN) begin
        cnt <= cnt_nxt;
        if (cnt == CNT_MAX) sat_flag <= 1'b1;
      end
      // cnt lags the acceptance edge by one, so the latched duration is cnt_nxt
      if (end_ok) begin
        cycles_o <= cnt_nxt;
        if (!final_test) begin
          if (t == LAST_T) begin
            t   <= '0;
            run <= run + 1'b1;
          end else begin
            t <= t + 1'b1;
          end
        end
      end
      if ((state != ERR) && (state_nxt == ERR))
        err_code_o <= wd_hit ? 2'd2 : (ooo ? 2'd1 : 2'd3);
    end
  end

  assign test_idx_o = t;
  assign run_idx_o  = run;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// Directed bench for checkpoint_monitor: nominal runs, glitches, ordering, reset, saturation, watchdog.
module tb_checkpoint_monitor;
  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [15:0] bus, bus2;

  logic        sp, ep, cv, done, err;
  logic [3:0]  tidx, ridx;
  logic [31:0] cyc;
  logic [1:0]  code;

  logic        sp2, ep2, cv2, done2, err2;
  logic [3:0]  tidx2, ridx2;
  logic [7:0]  cyc2;
  logic [1:0]  code2;

  int n_chk = 0, n_fail = 0;
  int n_sp = 0, n_ep = 0;
  logic [31:0] cq[$];
  int gaps[3] = '{500, 1200, 800};

  always #5 clk = ~clk;

  checkpoint_monitor u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .checkbits_i(bus),
    .start_pulse_o(sp), .end_pulse_o(ep), .test_idx_o(tidx), .run_idx_o(ridx),
    .cycles_o(cyc), .cycles_valid_o(cv), .done_o(done), .error_o(err), .err_code_o(code)
  );

  checkpoint_monitor #(.CNT_W(8), .TIMEOUT(2000)) u_sat (
    .wb_clk_i(clk), .wb_rst_i(rst2), .checkbits_i(bus2),
    .start_pulse_o(sp2), .end_pulse_o(ep2), .test_idx_o(tidx2), .run_idx_o(ridx2),
    .cycles_o(cyc2), .cycles_valid_o(cv2), .done_o(done2), .error_o(err2), .err_code_o(code2)
  );

  always @(negedge clk) begin
    if (sp) n_sp++;
    if (ep) n_ep++;
    if (cv) cq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; leaves the word on the bus for n clocks
  task automatic wr(input logic [15:0] w, input int n);
    bus = w;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr2(input logic [15:0] w, input int n);
    bus2 = w;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_cyc(input string tag, input int exp);
    if (cq.size() == 0) chk({tag, "_present"}, 64'd0, 64'd1);
    else                chk(tag, 64'(cq.pop_front()), 64'(exp));
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({sp, ep, cv, done, err, code, tidx, ridx}), 64'd0);
    chk({tag, "_cyc"}, 64'(cyc), 64'd0);
  endtask

  task automatic pulse_rst;
    @(posedge clk); #1;
    rst = 1'b1; bus = 16'h0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int s0, e0;
    rst = 1'b1; rst2 = 1'b1; bus = 16'h0; bus2 = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // one-clock glitch, then a non-marker word
    wr(16'hAB00, 1);
    wr(16'h0000, 10);
    chk("glitch_nostart", 64'(n_sp), 64'd0);
    wr(16'h1234, 10);
    chk("nonmark_err", 64'(err), 64'd0);
    chk("nonmark_nostart", 64'(n_sp), 64'd0);

    // nominal: three runs of three tests
    for (int r = 0; r < 3; r++) begin
      for (int ti = 0; ti < 3; ti++) begin
        s0 = n_sp;
        if (r == 1 && ti == 0) begin
          wr(16'hAB00, 250);
          wr(16'h1234, 250);
        end else begin
          wr({8'hAB, 4'(ti), 4'h0}, gaps[ti]);
        end
        wr({8'hAB, 4'(ti), 4'h1}, 20);
        chk("start_once", 64'(n_sp - s0), 64'd1);
        pop_cyc("cycles", gaps[ti]);
        if (ti == 2 && r < 2) chk("run_idx", 64'(ridx), 64'(r + 1));
      end
    end
    chk("done", 64'(done), 64'd1);
    chk("nominal_err", 64'(err), 64'd0);
    chk("final_run", 64'(ridx), 64'd2);
    chk("end_count", 64'(n_ep), 64'd9);
    s0 = n_sp;
    wr(16'hAB00, 20);
    chk("done_ignores", 64'(n_sp - s0), 64'd0);
    chk("done_sticky", 64'(done), 64'd1);

    // reset in the middle of test 1
    pulse_rst();
    chk("rst_clears_done", 64'(done), 64'd0);
    wr(16'hAB00, 100);
    wr(16'hAB01, 20);
    pop_cyc("mid_cyc0", 100);
    wr(16'hAB10, 30);
    chk("mid_tidx", 64'(tidx), 64'd1);
    #3 rst = 1'b1; bus = 16'h0;
    #1 chk_zero("mid_rst");
    @(posedge clk); #1 rst = 1'b0;
    s0 = n_sp;
    wr(16'hAB00, 20);
    chk("restart_start", 64'(n_sp - s0), 64'd1);
    chk("restart_err", 64'(err), 64'd0);
    chk("restart_tidx", 64'(tidx), 64'd0);

    // ordering error
    pulse_rst();
    wr(16'hAB10, 20);
    chk("ooo_err", 64'(err), 64'd1);
    chk("ooo_code", 64'(code), 64'd1);
    s0 = n_sp; e0 = n_ep;
    wr(16'hAB00, 20);
    wr(16'hAB01, 20);
    chk("ooo_no_start", 64'(n_sp - s0), 64'd0);
    chk("ooo_no_end", 64'(n_ep - e0), 64'd0);
    chk("ooo_code_frozen", 64'(code), 64'd1);

    // saturation on the 8-bit instance
    @(posedge clk); #1 rst2 = 1'b0;
    wr2(16'hAB00, 300);
    wr2(16'hAB01, 10);
    chk("sat_cycles", 64'(cyc2), 64'd255);
    chk("sat_err", 64'(err2), 64'd1);
    chk("sat_code", 64'(code2), 64'd3);

    // watchdog from reset release, no markers
    @(posedge clk); #1 rst2 = 1'b1; bus2 = 16'h0;
    @(posedge clk); #1 rst2 = 1'b0;
    chk("wd_rst_err", 64'(err2), 64'd0);
    repeat (1999) @(posedge clk);
    @(negedge clk);
    chk("wd_before", 64'(err2), 64'd0);
    @(negedge clk);
`ifdef CHKMON_TIMEOUT_EN
    chk("wd_err", 64'(err2), 64'd1);
    chk("wd_code", 64'(code2), 64'd2);
`else
    repeat (100) @(negedge clk);
    chk("wd_off_err", 64'(err2), 64'd0);
    chk("wd_off_code", 64'(code2), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
